dmem_stage: RTL
===============

DMEM_STAGE -- requirements
Module: dmem_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 256: number of 64-bit data words; word-addressed, valid addresses 0..DEPTH-1.
REQ-002 SHALL have parameter LATENCY, default 2: cycles per memory access, legal range 1..8.
REQ-003 SHALL have parameter DATA_W, default 64: width of valA, valE and valM.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 M_valid  input  1  M-register content is a real instruction, not a bubble.
REQ-007 M_icode  input  4  instruction code.
REQ-008 M_stat  input  3  incoming status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-009 M_valA  input  DATA_W  store data, or address for ret/popq.
REQ-010 M_valE  input  DATA_W  address for rmmovq/mrmovq/call/pushq, and passthrough value.
REQ-011 M_dstE, M_dstM  input  4 each  destination register IDs.
REQ-012 m_stall  output  1  combinational; the M register and everything upstream shall hold.
REQ-013 m_valid, m_icode, m_stat, m_valE, m_valM, m_dstE, m_dstM  output  1/4/3/DATA_W/DATA_W/4/4  registered results to write-back.

Function
REQ-014 Memory ops: write = icode 4 (rmmovq), 8 (call), 10 (pushq), address M_valE, data M_valA.
REQ-015 Memory ops: read = icode 5 (mrmovq), address M_valE; icode 9 (ret) and 11 (popq), address M_valA.
REQ-016 All other icodes SHALL be non-memory ops.
REQ-017 dmem_error SHALL be asserted when M_valid, the op is a memory op, M_stat==1 and the full-width address is >= DEPTH.
REQ-018 An op is "active" when M_valid, it is a memory op, M_stat==1 and dmem_error==0.
REQ-019 An internal counter cnt (0..LATENCY-1) SHALL define the state: IDLE = cnt==0, BUSY = cnt!=0.
REQ-020 m_stall SHALL equal active AND (cnt != LATENCY-1); with LATENCY=1 it SHALL always be 0.
REQ-021 Each edge with active and stalled: cnt <= cnt+1, with no output or memory update.
REQ-022 An edge "completes" when M_valid is 1 and the op is not stalled.
REQ-023 A completing edge SHALL set cnt <= 0.
REQ-024 A completing edge SHALL register m_valid=1 and copy m_icode, m_valE, m_dstE, m_dstM from the inputs.
REQ-025 A write commits mem[address] exactly once, on its completing edge only.
REQ-026 A read registers m_valM = mem[address] on its completing edge.
REQ-027 A read on the edge after a write to the same address SHALL return the written data.
REQ-028 On a completing edge for a non-memory, errored or non-AOK op: m_valM=0 and no memory write.
REQ-029 m_stat SHALL be 3 (ADR) when dmem_error, otherwise M_stat.
REQ-030 An incoming non-AOK M_stat SHALL suppress all memory access.
REQ-031 A non-memory op, errored op or non-AOK op SHALL complete in 1 cycle with no stall.
REQ-032 An edge with M_valid=0 SHALL register m_valid=0 (bubble) and hold every other output.
REQ-033 While m_stall=1, m_valid SHALL be 0 from the second stalled cycle on.
REQ-034 The upstream stage SHALL hold the M_* inputs stable while m_stall=1.
REQ-035 If M_valid drops while BUSY, cnt SHALL return to 0 and the op is abandoned with no write.
REQ-036 Memory contents SHALL initialise to 0 at time zero; reset SHALL NOT clear memory.

Reset
REQ-037 reset assertion SHALL immediately force cnt=0 and every m_* output to 0.
REQ-038 m_stall SHALL follow its inputs combinationally, given cnt=0.
REQ-039 A write pending in BUSY when reset asserts SHALL be discarded, leaving memory unchanged.
REQ-040 After reset deasserts, the first edge SHALL behave as IDLE.

Verification
REQ-041 LATENCY=2, rmmovq (icode 4), valE=16, valA=0xDEAD -> m_stall=1 for 1 cycle; next edge m_valid=1, m_stat=1, mem[16]=0xDEAD.
REQ-042 mrmovq (icode 5), valE=16, right after REQ-041 -> 1 stall cycle, then m_valM=0xDEAD, m_valid=1.
REQ-043 pushq (icode 10), valE=256, DEPTH=256 -> no stall; m_stat=3, m_valM=0, no memory write.
REQ-044 popq (icode 11), M_stat=4, valA=8 -> no stall; m_stat=4, m_valM=0, mem[8] unchanged.
REQ-045 LATENCY=3, call (icode 8) to address 40, reset pulsed in the 2nd stall cycle -> outputs 0 at once; mem[40] still 0.
REQ-046 LATENCY=1, alternating opq (icode 6) and mrmovq -> m_stall never 1; one result per cycle.

Source files
------------

// File: rtl/dmem_stage.sv
// Data-memory pipeline stage: multi-cycle word-addressed memory access
// with address checking, stall generation and registered write-back bundle.
module dmem_stage #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M_valid,
  input  logic [3:0]        M_icode,
  input  logic [2:0]        M_stat,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic              m_stall,
  output logic              m_valid,
  output logic [3:0]        m_icode,
  output logic [2:0]        m_stat,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_ADR = 3'd3;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic [CW-1:0]     r_cnt;
  logic              r_valid;
  logic [3:0]        r_icode;
  logic [2:0]        r_stat;
  logic [DATA_W-1:0] r_valE;
  logic [DATA_W-1:0] r_valM;
  logic [3:0]        r_dstE;
  logic [3:0]        r_dstM;

  logic              w_wr;
  logic              w_rd;
  logic              w_use_a;
  logic              w_mem;
  logic [DATA_W-1:0] w_addr;
  logic [AW-1:0]     w_idx;
  logic              w_ok;
  logic              w_err;
  logic              w_active;
  logic              w_last;
  logic              w_done;
  logic              w_we;

  always_comb begin
    w_wr    = 1'b0;
    w_rd    = 1'b0;
    w_use_a = 1'b0;
    case (M_icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: w_wr = 1'b1;
      I_MRMOVQ: w_rd = 1'b1;
      I_RET, I_POPQ: begin
        w_rd    = 1'b1;
        w_use_a = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_mem    = w_wr | w_rd;
  assign w_addr   = w_use_a ? M_valA : M_valE;
  assign w_idx    = w_addr[AW-1:0];
  assign w_ok     = M_valid & w_mem & (M_stat == S_AOK);
  assign w_err    = w_ok & (w_addr >= DATA_W'(DEPTH));
  assign w_active = w_ok & ~w_err;
  assign w_last   = (r_cnt == CW'(LATENCY - 1));
  assign m_stall  = w_active & ~w_last;
  assign w_done   = M_valid & ~m_stall;
  // Gate on reset so a pending store is dropped if reset is held over an edge
  assign w_we     = w_done & w_active & w_wr & ~reset;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_idx] <= M_valA;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_icode <= '0;
      r_stat  <= '0;
      r_valE  <= '0;
      r_valM  <= '0;
      r_dstE  <= '0;
      r_dstM  <= '0;
    end else if (!M_valid) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (m_stall) begin
      r_cnt   <= r_cnt + 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_cnt   <= '0;
      r_valid <= 1'b1;
      r_icode <= M_icode;
      r_stat  <= w_err ? S_ADR : M_stat;
      r_valE  <= M_valE;
      r_valM  <= (w_active & w_rd) ? r_mem[w_idx] : '0;
      r_dstE  <= M_dstE;
      r_dstM  <= M_dstM;
    end
  end

  assign m_valid = r_valid;
  assign m_icode = r_icode;
  assign m_stat  = r_stat;
  assign m_valE  = r_valE;
  assign m_valM  = r_valM;
  assign m_dstE  = r_dstE;
  assign m_dstM  = r_dstM;

endmodule
